// File: rtl/router_pkt_tx_pkg.sv
// Shared router definitions: header field layout, config limits,
// transmit FSM encoding and the parity corruption mask.
package router_pkt_tx_pkg;

    // Header byte layout: {length[5:0], dest_addr[1:0]}
    localparam int LEN_MSB  = 7;
    localparam int LEN_LSB  = 2;
    localparam int ADDR_MSB = 1;
    localparam int ADDR_LSB = 0;

    localparam logic [1:0] ADDR_INVALID        = 2'd3;
    localparam logic [5:0] MAX_LEN             = 6'd63;
    localparam logic [7:0] PARITY_CORRUPT_MASK = 8'h01;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HEADER  = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_PARITY  = 3'd3,
        ST_GAP     = 3'd4
    } tx_state_t;

    // Assemble the header byte from length and destination
    function automatic logic [7:0] make_header(input logic [5:0] len,
                                               input logic [1:0] addr);
        logic [7:0] hdr;
        hdr = 8'h00;
        hdr[LEN_MSB:LEN_LSB]   = len;
        hdr[ADDR_MSB:ADDR_LSB] = addr;
        return hdr;
    endfunction

    // A packet request is legal only for a real port and a non-empty payload
    function automatic logic cfg_valid(input logic [5:0] len,
                                       input logic [1:0] addr);
        return (addr != ADDR_INVALID) && (len != 6'd0) && (len <= MAX_LEN);
    endfunction

endpackage

// File: rtl/router_pkt_tx_parity.sv
// Byte-wide parity accumulator: clear, load a starting value, or fold in a byte.
module router_pkt_tx_parity
    import router_pkt_tx_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       xor_en,
    input  logic [7:0] xor_val,
    output logic [7:0] acc
);

    // Running XOR register; clear wins over load, load wins over xor
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc <= 8'h00;
        end else if (clr) begin
            acc <= 8'h00;
        end else if (load) begin
            acc <= load_val;
        end else if (xor_en) begin
            acc <= acc ^ xor_val;
        end else begin
            acc <= acc;
        end
    end

endmodule

// File: rtl/router_pkt_tx.sv
// Router source-side packet generator: sends header, an incrementing payload
// seeded per packet, and a parity byte, honouring the router busy signal.
module router_pkt_tx
    import router_pkt_tx_pkg::*;
#(
    parameter int GAP_CYCLES = 2,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       dest_addr,
    input  logic [5:0]       length,
    input  logic [7:0]       seed,
    input  logic             corrupt,
    input  logic             busy,
    output logic [7:0]       data_out,
    output logic             pkt_valid,
    output logic             tx_active,
    output logic             pkt_done,
    output logic             cfg_err,
    output logic [CNT_W-1:0] pkt_count
);

    localparam logic [3:0]       GAP_LOAD = 4'(GAP_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    tx_state_t  state_r;
    logic [5:0] len_r;
    logic [7:0] seed_r;
    logic       corrupt_r;
    logic [5:0] idx_r;
    logic [3:0] gap_r;

    logic [7:0] hdr_s;
    logic       start_ok_s;
    logic [7:0] payload_byte_s;
    logic [7:0] par_acc_s;
    logic [7:0] par_final_s;
    logic       par_clr_s;
    logic       par_load_s;
    logic       par_xor_s;
    logic [7:0] par_xor_val_s;

    // Decode of the current request and the next payload/parity bytes
    always_comb begin
        hdr_s          = make_header(length, dest_addr);
        start_ok_s     = start && cfg_valid(length, dest_addr);
        payload_byte_s = seed_r + {2'b00, idx_r};
        if (corrupt_r) begin
            par_final_s = par_acc_s ^ PARITY_CORRUPT_MASK;
        end else begin
            par_final_s = par_acc_s;
        end
    end

    // Parity accumulator control, mirroring each byte the FSM transfers
    always_comb begin
        par_clr_s     = 1'b0;
        par_load_s    = 1'b0;
        par_xor_s     = 1'b0;
        par_xor_val_s = 8'h00;
        case (state_r)
            ST_IDLE: begin
                if (start_ok_s) begin
                    par_load_s = 1'b1;
                end else begin
                    par_load_s = 1'b0;
                end
            end
            ST_HEADER: begin
                if (!busy) begin
                    par_xor_s     = 1'b1;
                    par_xor_val_s = seed_r;
                end else begin
                    par_xor_s = 1'b0;
                end
            end
            ST_PAYLOAD: begin
                if (!busy && (idx_r < len_r)) begin
                    par_xor_s     = 1'b1;
                    par_xor_val_s = payload_byte_s;
                end else begin
                    par_xor_s = 1'b0;
                end
            end
            ST_PARITY: begin
                if (!busy) begin
                    par_clr_s = 1'b1;
                end else begin
                    par_clr_s = 1'b0;
                end
            end
            default: begin
                par_clr_s = 1'b0;
            end
        endcase
    end

    router_pkt_tx_parity u_parity (
        .clk      (clk),
        .rst      (rst),
        .clr      (par_clr_s),
        .load     (par_load_s),
        .load_val (hdr_s),
        .xor_en   (par_xor_s),
        .xor_val  (par_xor_val_s),
        .acc      (par_acc_s)
    );

    // Transmit FSM with registered byte stream, status pulses and packet counter
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            len_r     <= 6'd0;
            seed_r    <= 8'h00;
            corrupt_r <= 1'b0;
            idx_r     <= 6'd0;
            gap_r     <= 4'd0;
            data_out  <= 8'h00;
            pkt_valid <= 1'b0;
            tx_active <= 1'b0;
            pkt_done  <= 1'b0;
            cfg_err   <= 1'b0;
            pkt_count <= '0;
        end else begin
            pkt_done <= 1'b0;
            cfg_err  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start_ok_s) begin
                        len_r     <= length;
                        seed_r    <= seed;
                        corrupt_r <= corrupt;
                        idx_r     <= 6'd0;
                        data_out  <= hdr_s;
                        pkt_valid <= 1'b1;
                        tx_active <= 1'b1;
                        state_r   <= ST_HEADER;
                    end else if (start) begin
                        cfg_err   <= 1'b1;
                        data_out  <= 8'h00;
                        pkt_valid <= 1'b0;
                    end else begin
                        data_out  <= 8'h00;
                        pkt_valid <= 1'b0;
                    end
                end
                ST_HEADER: begin
                    if (!busy) begin
                        data_out <= seed_r;
                        idx_r    <= 6'd1;
                        state_r  <= ST_PAYLOAD;
                    end else begin
                        state_r <= ST_HEADER;
                    end
                end
                ST_PAYLOAD: begin
                    if (busy) begin
                        state_r <= ST_PAYLOAD;
                    end else if (idx_r < len_r) begin
                        data_out <= payload_byte_s;
                        idx_r    <= idx_r + 6'd1;
                    end else begin
                        data_out  <= par_final_s;
                        pkt_valid <= 1'b0;
                        state_r   <= ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    if (!busy) begin
                        data_out  <= 8'h00;
                        pkt_done  <= 1'b1;
                        pkt_count <= pkt_count + CNT_ONE;
                        gap_r     <= GAP_LOAD;
                        state_r   <= ST_GAP;
                    end else begin
                        state_r <= ST_PARITY;
                    end
                end
                ST_GAP: begin
                    if (gap_r <= 4'd1) begin
                        gap_r     <= 4'd0;
                        tx_active <= 1'b0;
                        state_r   <= ST_IDLE;
                    end else begin
                        gap_r <= gap_r - 4'd1;
                    end
                end
                default: begin
                    data_out  <= 8'h00;
                    pkt_valid <= 1'b0;
                    tx_active <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
